// File: rtl/sha256_pad_if.sv
// Byte-stream in / padded-block out bundle between the message source, the padder
// and the SHA-256 core.
interface sha256_pad_if;
    logic [7:0]   din;
    logic         din_valid;
    logic         din_last;
    logic         din_ready;
    logic [511:0] M_out;
    logic         M_valid;
    logic         core_done;
    logic         busy;
    logic         err;

    modport master (
        output din, din_valid, din_last, core_done,
        input  din_ready, M_out, M_valid, busy, err
    );

    modport slave (
        input  din, din_valid, din_last, core_done,
        output din_ready, M_out, M_valid, busy, err
    );
endinterface

// File: rtl/sha256_pad.sv
// Packs a 1..MAX_BYTES byte message into one FIPS 180-4 padded 512-bit block,
// pulses M_valid to the SHA-256 core and holds the block until core_done.
module sha256_pad #(
    parameter int unsigned MAX_BYTES = 55
) (
    input logic         clk,
    input logic         rst_n,
    sha256_pad_if.slave bus
);

    typedef enum logic [2:0] {
        StLoad,
        StDrop,
        StPad,
        StIssue,
        StWait
    } state_e;

    localparam logic [5:0] LastIdx = 6'(MAX_BYTES - 1);

    state_e       state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [511:0] buf_q, buf_d;
    logic         err_q, err_d;
    logic         xfer;

    assign xfer = bus.din_valid & bus.din_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_d   = err_q;
        case (state_q)
            StLoad: begin
                if (xfer) begin
                    for (int i = 0; i < 56; i++) begin
                        if (cnt_q == 6'(i)) buf_d[511-8*i -: 8] = bus.din;
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (bus.din_last) begin
                        state_d = StPad;
                    end else if (cnt_q == LastIdx) begin
                        err_d   = 1'b1;
                        state_d = StDrop;
                    end
                end
            end
            StDrop: begin
                // Swallow the rest of the oversized message; nothing is issued.
                if (xfer && bus.din_last) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end
            StPad: begin
                // cnt_q now holds the message length L.
                for (int i = 0; i < 56; i++) begin
                    if (6'(i) == cnt_q) begin
                        buf_d[511-8*i -: 8] = 8'h80;
                    end else if (6'(i) > cnt_q) begin
                        buf_d[511-8*i -: 8] = 8'h00;
                    end
                end
                buf_d[63:0] = {55'd0, cnt_q, 3'b000};
                state_d     = StIssue;
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (bus.core_done) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLoad;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    // Gated by rst_n so the source sees no acceptance while reset is held.
    assign bus.din_ready = rst_n & ((state_q == StLoad) | (state_q == StDrop));
    assign bus.M_valid   = (state_q == StIssue);
    assign bus.busy      = (state_q == StLoad) ? (cnt_q != 6'd0) : 1'b1;
    assign bus.M_out     = buf_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_sha256_pad.sv
// Randomized bench for sha256_pad: a message-level model predicts every output each cycle,
// with literal checks on the reference blocks.
module tb_sha256_pad;

    localparam int MaxBytes = 55;

    logic clk;
    logic rst_n;
    sha256_pad_if bus ();

    sha256_pad #(.MAX_BYTES(MaxBytes)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int dut_blocks = 0;

    // Model: bytes of the message being collected, the last complete message, and how many
    // cycles have elapsed since that message's final byte was taken (0 = accepting input).
    logic [7:0] cur [56];
    logic [7:0] held[56];
    logic [7:0] tx  [64];
    int cur_len = 0;
    int held_len = 0;
    int stage = 0;
    bit dropping = 0;
    bit m_err = 0;
    int blocks_exp = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] raw_blk(input logic [7:0] a[56], input int len);
        logic [511:0] b = '0;
        for (int i = 0; i < len; i++) b[511-8*i -: 8] = a[i];
        return b;
    endfunction

    function automatic logic [511:0] pad_blk(input logic [7:0] a[56], input int len);
        logic [511:0] b = raw_blk(a, len);
        b[511-8*len -: 8] = 8'h80;
        b[63:0] = 64'(len * 8);
        return b;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cur_len = 0; stage = 0; dropping = 0; m_err = 0;
            end else if (stage == 0) begin
                if (bus.din_valid) begin
                    if (dropping) begin
                        if (bus.din_last) dropping = 0;
                    end else begin
                        cur[cur_len] = bus.din;
                        cur_len++;
                        if (bus.din_last) begin
                            held = cur;
                            held_len = cur_len;
                            cur_len = 0;
                            stage = 1;
                            blocks_exp++;
                        end else if (cur_len == MaxBytes) begin
                            m_err = 1;
                            dropping = 1;
                            cur_len = 0;
                        end
                    end
                end
            end else if (stage < 3) begin
                stage++;
            end else if (bus.core_done) begin
                stage = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_ready", 512'(bus.din_ready), 512'(0));
                chk("rst_valid", 512'(bus.M_valid), 512'(0));
                chk("rst_busy", 512'(bus.busy), 512'(0));
                chk("rst_err", 512'(bus.err), 512'(0));
                chk("rst_mout", bus.M_out, 512'(0));
            end else begin
                if (bus.M_valid === 1'b1) dut_blocks++;
                chk("din_ready", 512'(bus.din_ready), 512'(stage == 0));
                chk("M_valid", 512'(bus.M_valid), 512'(stage == 2));
                chk("err", 512'(bus.err), 512'(m_err));
                if (!dropping) begin
                    chk("busy", 512'(bus.busy), 512'(stage != 0 || cur_len > 0));
                    if (stage == 0) chk("M_out", bus.M_out, raw_blk(cur, cur_len));
                    else if (stage == 1) chk("M_out", bus.M_out, raw_blk(held, held_len));
                    else chk("M_out", bus.M_out, pad_blk(held, held_len));
                end
            end
        end
    end

    task automatic finish_run();
        n_cmp++;
        if (dut_blocks != blocks_exp) begin
            n_bad++;
            $display("FAIL block_count: got %0d expected %0d", dut_blocks, blocks_exp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int guard = 0;
        bit done = 0;
        if ($urandom_range(0, 3) == 0) begin
            // Idle cycle: din_last without din_valid and a stray core_done must be ignored.
            bus.din_valid = 1'b0;
            bus.din = 8'($urandom);
            bus.din_last = 1'($urandom);
            bus.core_done = 1'($urandom);
            @(posedge clk); #1;
            bus.core_done = 1'b0;
        end
        bus.din = b;
        bus.din_last = last;
        bus.din_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = bus.din_ready;
            @(posedge clk); #1;
            guard++;
            if (guard > 200) begin
                n_cmp++; n_bad++;
                $display("FAIL send_timeout: got no din_ready expected din_ready within 200 cycles");
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $fatal(1, "stalled");
            end
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic send_tx(input int n);
        for (int i = 0; i < n; i++) send_byte(tx[i], i == n - 1);
    endtask

    task automatic wait_block(input bit hold_valid);
        int g = 0;
        bit got = 0;
        if (hold_valid) begin
            bus.din_valid = 1'b1;
            bus.din = 8'($urandom);
            bus.din_last = 1'($urandom);
        end
        while (!got && g < 20) begin
            @(negedge clk);
            got = bus.M_valid;
            g++;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL block_timeout: got no M_valid expected M_valid within 20 cycles");
        end
    endtask

    task automatic release_core();
        @(posedge clk); #1;
        repeat ($urandom_range(0, 4)) begin
            @(posedge clk); #1;
        end
        bus.core_done = 1'b1;
        @(posedge clk); #1;
        bus.core_done = 1'b0;
        bus.din_valid = 1'b0;
    endtask

    task automatic load_abc();
        tx[0] = 8'h61; tx[1] = 8'h62; tx[2] = 8'h63;
        send_tx(3);
    endtask

    task automatic check_abc(input string tag);
        chk({tag, "_head"}, 512'(bus.M_out[511:480]), 512'(32'h61626380));
        chk({tag, "_zero"}, 512'(bus.M_out[479:64]), 512'(0));
        chk({tag, "_len"}, 512'(bus.M_out[63:0]), 512'(64'h18));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.din = '0; bus.din_valid = 1'b0; bus.din_last = 1'b0; bus.core_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // "abc"
        load_abc();
        wait_block(1'b1);
        check_abc("abc");
        release_core();

        // 33-byte compressed key 0x02,0x01..0x20
        tx[0] = 8'h02;
        for (int i = 1; i < 33; i++) tx[i] = 8'(i);
        send_tx(33);
        wait_block(1'b0);
        chk("key_b32", 512'(bus.M_out[511-8*32 -: 8]), 512'(8'h20));
        chk("key_pad", 512'(bus.M_out[511-8*33 -: 8]), 512'(8'h80));
        chk("key_zero", 512'(bus.M_out[511-8*34 : 64]), 512'(0));
        chk("key_len", 512'(bus.M_out[63:0]), 512'(64'h108));
        release_core();
        @(negedge clk);
        chk("key_busy_after", 512'(bus.busy), 512'(0));
        @(posedge clk); #1;

        // 55 x 0xFF: the longest legal message
        for (int i = 0; i < 55; i++) tx[i] = 8'hFF;
        send_tx(55);
        wait_block(1'b1);
        chk("max_b54", 512'(bus.M_out[511-8*54 -: 8]), 512'(8'hFF));
        chk("max_pad", 512'(bus.M_out[511-8*55 -: 8]), 512'(8'h80));
        chk("max_len", 512'(bus.M_out[63:0]), 512'(64'h1B8));
        chk("max_err", 512'(bus.err), 512'(0));
        release_core();

        // 56 x 0xAA overflows, then "abc" must come out clean
        for (int i = 0; i < 56; i++) tx[i] = 8'hAA;
        send_tx(56);
        @(negedge clk);
        chk("ovf_err", 512'(bus.err), 512'(1));
        @(posedge clk); #1;
        load_abc();
        wait_block(1'b1);
        check_abc("ovf_abc");
        chk("ovf_err_sticky", 512'(bus.err), 512'(1));
        release_core();

        // Random traffic, with occasional oversize messages
        for (int m = 0; m < 25; m++) begin
            int n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(56, 60))
                                                : int'($urandom_range(1, MaxBytes));
            for (int i = 0; i < n; i++) tx[i] = 8'($urandom);
            send_tx(n);
            if (n <= MaxBytes) begin
                wait_block(1'($urandom));
                release_core();
            end
        end

        // Reset mid-message, then "abc" again
        for (int i = 0; i < 10; i++) send_byte(8'(i + 1), 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 512'(bus.din_ready), 512'(0));
        chk("arst_busy", 512'(bus.busy), 512'(0));
        chk("arst_err", 512'(bus.err), 512'(0));
        chk("arst_mout", bus.M_out, 512'(0));
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        load_abc();
        wait_block(1'b0);
        check_abc("post_rst_abc");
        release_core();
        repeat (3) @(posedge clk);
        finish_run();
    end

    initial begin
        #200000;
        n_cmp++; n_bad++;
        $display("FAIL global_timeout: got no finish expected finish before 200000 time units");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
